ws2812_frame_sched: RTL and testbench

//  Frame scheduler for the ws2812 channel controller: turns the host GRB byte stream into linked pixel

---
 rtl/ws2812_pkg.sv | 19 +
 rtl/ws2812_refresh_timer.sv | 52 +++++
 rtl/ws2812_frame_sched.sv | 147 ++++++++++++++
 tb/tb_ws2812_frame_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the ws2812 frame scheduler.
package ws2812_pkg;

  typedef enum logic [2:0] {IDLE, RECV, LINK, TERM, ISSUE, BUSY} state_t;

  localparam int RAM_AW = 6;

  // RAM lane enables: link field plus the three colour bytes of a record
  localparam logic [3:0] LANE_LINK = 4'b1000;
  localparam logic [3:0] LANE_G    = 4'b0100;
  localparam logic [3:0] LANE_R    = 4'b0010;
  localparam logic [3:0] LANE_B    = 4'b0001;

  // Link to the following record; wraps so the last RAM slot points at 0
  function automatic logic [RAM_AW-1:0] next_link(input logic [RAM_AW:0] pix);
    return RAM_AW'(pix + 7'd1);
  endfunction

endpackage

// File: rtl/ws2812_refresh_timer.sv
// Refresh timer: after load, stays busy for pix_cnt*24 bit times plus the
// reset-code time, then pulses done for one cycle.
module ws2812_refresh_timer #(
  parameter int BIT_CYCLES = 250,
  parameter int RST_CYCLES = 10016
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       load,
  input  logic [6:0] pix_cnt,
  output logic       busy,
  output logic       done
);

  logic [10:0] bits_left_reg;
  logic [7:0]  bit_cnt_reg;
  logic [13:0] rst_cnt_reg;

  // Bit-time phase first, then reset-code countdown, then release busy
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      bits_left_reg <= '0;
      bit_cnt_reg   <= '0;
      rst_cnt_reg   <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        busy          <= 1'b1;
        bits_left_reg <= 11'(pix_cnt) * 11'd24;
        bit_cnt_reg   <= '0;
        rst_cnt_reg   <= 14'(RST_CYCLES - 1);
      end else if (busy) begin
        if (bits_left_reg != '0) begin
          if (bit_cnt_reg == 8'(BIT_CYCLES - 1)) begin
            bit_cnt_reg   <= '0;
            bits_left_reg <= bits_left_reg - 11'd1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 8'd1;
          end
        end else if (rst_cnt_reg != '0) begin
          rst_cnt_reg <= rst_cnt_reg - 14'd1;
        end else begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_sched.sv
// Frame scheduler: packs host G,R,B bytes into linked pixel records in the
// layer RAM, terminates the chain, issues the refresh and blocks new frames
// until the refresh time has elapsed.
module ws2812_frame_sched import ws2812_pkg::*; #(
  parameter int BIT_CYCLES = 250,
  parameter int RST_CYCLES = 10016,
  parameter int PIXELS_MAX = 64
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              frame_start_in,
  input  logic              frame_end_in,
  input  logic              byte_rdy_in,
  input  logic [7:0]        byte_data_in,
  output logic [RAM_AW-1:0] wr_addr_out,
  output logic [3:0]        byte_en_out,
  output logic [7:0]        byte_data_out,
  output logic              layer_en_out,
  output logic              frame_rdy_out,
  output logic              busy_out,
  output logic              frame_drop_out
);

  localparam logic [6:0] PIX_FULL = 7'(PIXELS_MAX);

  state_t     state_reg;
  logic [6:0] pix_cnt_reg;
  logic [3:0] lane_reg;
  logic       end_pend_reg;
  logic       end_req;
  logic       timer_load;
  logic       timer_done;

  assign end_req    = end_pend_reg | frame_end_in;
  assign timer_load = (state_reg == ISSUE);

  ws2812_refresh_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .RST_CYCLES (RST_CYCLES)
  ) u_timer (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .load     (timer_load),
    .pix_cnt  (pix_cnt_reg),
    .busy     (busy_out),
    .done     (timer_done)
  );

  // Frame FSM with registered RAM write port and status pulses
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= IDLE;
      pix_cnt_reg    <= '0;
      lane_reg       <= LANE_G;
      end_pend_reg   <= 1'b0;
      wr_addr_out    <= '0;
      byte_en_out    <= '0;
      byte_data_out  <= '0;
      layer_en_out   <= 1'b0;
      frame_rdy_out  <= 1'b0;
      frame_drop_out <= 1'b0;
    end else begin
      layer_en_out   <= 1'b0;
      frame_rdy_out  <= 1'b0;
      frame_drop_out <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A simultaneous end is dropped: start wins
          if (frame_start_in) begin
            state_reg    <= RECV;
            pix_cnt_reg  <= '0;
            lane_reg     <= LANE_G;
            end_pend_reg <= 1'b0;
          end
        end
        RECV: begin
          if (frame_start_in) begin
            pix_cnt_reg  <= '0;
            lane_reg     <= LANE_G;
            end_pend_reg <= 1'b0;
          end else if (byte_rdy_in && pix_cnt_reg != PIX_FULL) begin
            layer_en_out  <= 1'b1;
            wr_addr_out   <= pix_cnt_reg[RAM_AW-1:0];
            byte_en_out   <= lane_reg;
            byte_data_out <= byte_data_in;
            end_pend_reg  <= end_req;
            case (lane_reg)
              LANE_G:  lane_reg  <= LANE_R;
              LANE_R:  lane_reg  <= LANE_B;
              default: state_reg <= LINK;
            endcase
          end else if (end_req) begin
            // Any partial pixel is simply forgotten
            end_pend_reg <= 1'b0;
            lane_reg     <= LANE_G;
            state_reg    <= (pix_cnt_reg == '0) ? IDLE : TERM;
          end
        end
        LINK: begin
          layer_en_out  <= 1'b1;
          wr_addr_out   <= pix_cnt_reg[RAM_AW-1:0];
          byte_en_out   <= LANE_LINK;
          byte_data_out <= {2'b00, next_link(pix_cnt_reg)};
          lane_reg      <= LANE_G;
          state_reg     <= RECV;
          if (frame_start_in) begin
            pix_cnt_reg  <= '0;
            end_pend_reg <= 1'b0;
          end else begin
            pix_cnt_reg  <= pix_cnt_reg + 7'd1;
            end_pend_reg <= end_req;
          end
        end
        TERM: begin
          layer_en_out   <= 1'b1;
          wr_addr_out    <= RAM_AW'(pix_cnt_reg - 7'd1);
          byte_en_out    <= LANE_LINK;
          byte_data_out  <= 8'h00;
          state_reg      <= ISSUE;
          frame_drop_out <= frame_start_in;
        end
        ISSUE: begin
          frame_rdy_out  <= 1'b1;
          state_reg      <= BUSY;
          frame_drop_out <= frame_start_in;
        end
        BUSY: begin
          // busy_out is already low when done is seen, so a start is accepted
          if (timer_done) begin
            if (frame_start_in) begin
              state_reg    <= RECV;
              pix_cnt_reg  <= '0;
              lane_reg     <= LANE_G;
              end_pend_reg <= 1'b0;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            frame_drop_out <= frame_start_in;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_frame_sched.sv
// Directed bench for the ws2812 frame scheduler, with short bit/reset times.
module tb_ws2812_frame_sched;

  localparam int BITC = 4;
  localparam int RSTC = 20;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic       frame_start_in = 1'b0;
  logic       frame_end_in = 1'b0;
  logic       byte_rdy_in = 1'b0;
  logic [7:0] byte_data_in = 8'h00;
  logic [5:0] wr_addr_out;
  logic [3:0] byte_en_out;
  logic [7:0] byte_data_out;
  logic       layer_en_out, frame_rdy_out, busy_out, frame_drop_out;

  int checks = 0;
  int errors = 0;
  logic [17:0] wlog[$];
  int rdy_total = 0;
  int drop_total = 0;

  always #5 clk_in = ~clk_in;

  ws2812_frame_sched #(.BIT_CYCLES(BITC), .RST_CYCLES(RSTC), .PIXELS_MAX(64)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .frame_start_in(frame_start_in), .frame_end_in(frame_end_in),
    .byte_rdy_in(byte_rdy_in), .byte_data_in(byte_data_in),
    .wr_addr_out(wr_addr_out), .byte_en_out(byte_en_out), .byte_data_out(byte_data_out),
    .layer_en_out(layer_en_out), .frame_rdy_out(frame_rdy_out),
    .busy_out(busy_out), .frame_drop_out(frame_drop_out)
  );

  // Record every RAM write and count status pulse cycles
  always @(negedge clk_in) begin
    if (layer_en_out) wlog.push_back({wr_addr_out, byte_en_out, byte_data_out});
    if (frame_rdy_out) rdy_total++;
    if (frame_drop_out) drop_total++;
  end

  function automatic logic [17:0] wr(input int a, input int be, input int d);
    return {a[5:0], be[3:0], d[7:0]};
  endfunction

  task automatic pulse_start();
    @(negedge clk_in); frame_start_in = 1'b1;
    @(negedge clk_in); frame_start_in = 1'b0;
  endtask

  task automatic pulse_end();
    @(negedge clk_in); frame_end_in = 1'b1;
    @(negedge clk_in); frame_end_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in); byte_rdy_in = 1'b1; byte_data_in = b;
    @(negedge clk_in); byte_rdy_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic send_pixel(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    send_byte(g); send_byte(r); send_byte(b);
  endtask

  task automatic wait_busy_rise(input string name);
    int n = 0;
    while (!busy_out && n < 20) begin @(negedge clk_in); n++; end
    checks++;
    if (!busy_out) begin errors++; $display("FAIL %s busy_rise got=0 want=1", name); end
  endtask

  task automatic wait_busy_fall(input string name, output int cycles);
    cycles = 0;
    while (busy_out && cycles < 20000) begin cycles++; @(negedge clk_in); end
    checks++;
    if (busy_out) begin errors++; $display("FAIL %s busy_timeout got=1 want=0", name); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    checks++;
    if ({wr_addr_out, byte_en_out, byte_data_out, layer_en_out, frame_rdy_out, busy_out, frame_drop_out} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {wr_addr_out, byte_en_out, byte_data_out, layer_en_out, frame_rdy_out, busy_out, frame_drop_out});
    end
    rst_n_in = 1'b1;
    @(negedge clk_in);
    $display("reset released");
  endtask

  task automatic test_one_pixel();
    int base, r0, bc;
    logic [17:0] exp[$];
    logic [17:0] got;
    base = wlog.size(); r0 = rdy_total;
    pulse_start(); send_pixel(8'h11, 8'h22, 8'h33); pulse_end();
    wait_busy_rise("one_pixel"); wait_busy_fall("one_pixel", bc);
    exp = '{wr(0, 4'b0100, 'h11), wr(0, 4'b0010, 'h22), wr(0, 4'b0001, 'h33),
            wr(0, 4'b1000, 'h01), wr(0, 4'b1000, 'h00)};
    checks++;
    if (wlog.size() - base != 5) begin errors++; $display("FAIL one_pixel write_count got=%0d want=5", wlog.size() - base); end
    foreach (exp[i]) begin
      got = (base + i < wlog.size()) ? wlog[base + i] : 18'bx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL one_pixel write%0d got=%h want=%h", i, got, exp[i]); end
    end
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL one_pixel frame_rdy got=%0d want=1", rdy_total - r0); end
    checks++;
    if (bc < 24*BITC + RSTC - 1 || bc > 24*BITC + RSTC + 1) begin
      errors++; $display("FAIL one_pixel busy_cycles got=%0d want=%0d", bc, 24*BITC + RSTC);
    end
    $display("frame one_pixel writes=%0d busy=%0d", wlog.size() - base, bc);
  endtask

  task automatic test_three_pixels();
    int base, r0, bc;
    logic [17:0] exp[$];
    logic [17:0] got;
    base = wlog.size(); r0 = rdy_total;
    pulse_start();
    for (int k = 1; k <= 3; k++) send_pixel(8'(10*k+1), 8'(10*k+2), 8'(10*k+3));
    pulse_end();
    wait_busy_rise("three_pixels"); wait_busy_fall("three_pixels", bc);
    exp = {};
    for (int k = 1; k <= 3; k++) begin
      exp.push_back(wr(k-1, 4'b0100, 10*k+1));
      exp.push_back(wr(k-1, 4'b0010, 10*k+2));
      exp.push_back(wr(k-1, 4'b0001, 10*k+3));
      exp.push_back(wr(k-1, 4'b1000, k));
    end
    exp.push_back(wr(2, 4'b1000, 0));
    checks++;
    if (wlog.size() - base != exp.size()) begin errors++; $display("FAIL three_pixels write_count got=%0d want=%0d", wlog.size() - base, exp.size()); end
    foreach (exp[i]) begin
      got = (base + i < wlog.size()) ? wlog[base + i] : 18'bx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL three_pixels write%0d got=%h want=%h", i, got, exp[i]); end
    end
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL three_pixels frame_rdy got=%0d want=1", rdy_total - r0); end
    checks++;
    if (bc < 72*BITC + RSTC - 1 || bc > 72*BITC + RSTC + 1) begin
      errors++; $display("FAIL three_pixels busy_cycles got=%0d want=%0d", bc, 72*BITC + RSTC);
    end
    $display("frame three_pixels writes=%0d busy=%0d", wlog.size() - base, bc);
  endtask

  task automatic test_partial();
    int base, r0, bc;
    logic [17:0] exp[$];
    logic [17:0] got;
    base = wlog.size(); r0 = rdy_total;
    pulse_start();
    send_pixel(8'hA1, 8'hA2, 8'hA3); send_pixel(8'hB1, 8'hB2, 8'hB3);
    send_byte(8'hC1); send_byte(8'hC2);
    pulse_end();
    wait_busy_rise("partial"); wait_busy_fall("partial", bc);
    exp = '{wr(0, 4'b0100, 'hA1), wr(0, 4'b0010, 'hA2), wr(0, 4'b0001, 'hA3), wr(0, 4'b1000, 1),
            wr(1, 4'b0100, 'hB1), wr(1, 4'b0010, 'hB2), wr(1, 4'b0001, 'hB3), wr(1, 4'b1000, 2),
            wr(2, 4'b0100, 'hC1), wr(2, 4'b0010, 'hC2), wr(1, 4'b1000, 0)};
    checks++;
    if (wlog.size() - base != exp.size()) begin errors++; $display("FAIL partial write_count got=%0d want=%0d", wlog.size() - base, exp.size()); end
    foreach (exp[i]) begin
      got = (base + i < wlog.size()) ? wlog[base + i] : 18'bx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL partial write%0d got=%h want=%h", i, got, exp[i]); end
    end
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL partial frame_rdy got=%0d want=1", rdy_total - r0); end
    checks++;
    if (bc < 48*BITC + RSTC - 1 || bc > 48*BITC + RSTC + 1) begin
      errors++; $display("FAIL partial busy_cycles got=%0d want=%0d", bc, 48*BITC + RSTC);
    end
    $display("frame partial writes=%0d busy=%0d", wlog.size() - base, bc);
  endtask

  task automatic test_empty_frame();
    int base, r0;
    base = wlog.size(); r0 = rdy_total;
    pulse_start(); pulse_end();
    repeat (10) @(negedge clk_in);
    checks++;
    if (wlog.size() - base != 0) begin errors++; $display("FAIL empty write_count got=%0d want=0", wlog.size() - base); end
    checks++;
    if (rdy_total - r0 != 0) begin errors++; $display("FAIL empty frame_rdy got=%0d want=0", rdy_total - r0); end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("FAIL empty busy got=%b want=0", busy_out); end
    $display("frame empty writes=%0d", wlog.size() - base);
  endtask

  task automatic test_byte_end_same();
    int base, r0, bc;
    logic [17:0] exp[$];
    logic [17:0] got;
    base = wlog.size(); r0 = rdy_total;
    pulse_start(); send_byte(8'h5A); send_byte(8'h6B);
    @(negedge clk_in); byte_rdy_in = 1'b1; byte_data_in = 8'h7C; frame_end_in = 1'b1;
    @(negedge clk_in); byte_rdy_in = 1'b0; frame_end_in = 1'b0;
    wait_busy_rise("byte_end"); wait_busy_fall("byte_end", bc);
    exp = '{wr(0, 4'b0100, 'h5A), wr(0, 4'b0010, 'h6B), wr(0, 4'b0001, 'h7C),
            wr(0, 4'b1000, 1), wr(0, 4'b1000, 0)};
    checks++;
    if (wlog.size() - base != 5) begin errors++; $display("FAIL byte_end write_count got=%0d want=5", wlog.size() - base); end
    foreach (exp[i]) begin
      got = (base + i < wlog.size()) ? wlog[base + i] : 18'bx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL byte_end write%0d got=%h want=%h", i, got, exp[i]); end
    end
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL byte_end frame_rdy got=%0d want=1", rdy_total - r0); end
    $display("frame byte_end writes=%0d busy=%0d", wlog.size() - base, bc);
  endtask

  task automatic test_drop();
    int base, b1, r0, d0, bc;
    logic [17:0] got;
    base = wlog.size(); r0 = rdy_total; d0 = drop_total;
    pulse_start(); send_pixel(8'h01, 8'h02, 8'h03); pulse_end();
    wait_busy_rise("drop");
    b1 = wlog.size();
    pulse_start(); send_pixel(8'h04, 8'h05, 8'h06); pulse_end();
    checks++;
    if (drop_total - d0 != 1) begin errors++; $display("FAIL drop pulse_cycles got=%0d want=1", drop_total - d0); end
    checks++;
    if (wlog.size() - b1 != 0) begin errors++; $display("FAIL drop writes_while_busy got=%0d want=0", wlog.size() - b1); end
    wait_busy_fall("drop", bc);
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL drop frame_rdy got=%0d want=1", rdy_total - r0); end
    b1 = wlog.size();
    pulse_start(); send_pixel(8'h07, 8'h08, 8'h09); pulse_end();
    wait_busy_rise("after_drop"); wait_busy_fall("after_drop", bc);
    checks++;
    if (wlog.size() - b1 != 5) begin errors++; $display("FAIL after_drop write_count got=%0d want=5", wlog.size() - b1); end
    got = (b1 < wlog.size()) ? wlog[b1] : 18'bx;
    checks++;
    if (got !== wr(0, 4'b0100, 'h07)) begin errors++; $display("FAIL after_drop first_write got=%h want=%h", got, wr(0, 4'b0100, 'h07)); end
    checks++;
    if (rdy_total - r0 != 2) begin errors++; $display("FAIL after_drop frame_rdy got=%0d want=2", rdy_total - r0); end
    $display("frame drop dropped=%0d writes=%0d", drop_total - d0, wlog.size() - base);
  endtask

  task automatic test_overflow();
    int base, r0, bc;
    logic [17:0] exp[$];
    logic [17:0] got;
    base = wlog.size(); r0 = rdy_total;
    pulse_start();
    for (int p = 0; p < 65; p++) send_pixel(8'(p), 8'(p + 64), 8'(p + 128));
    pulse_end();
    wait_busy_rise("overflow"); wait_busy_fall("overflow", bc);
    exp = {};
    for (int p = 0; p < 64; p++) begin
      exp.push_back(wr(p, 4'b0100, p));
      exp.push_back(wr(p, 4'b0010, p + 64));
      exp.push_back(wr(p, 4'b0001, p + 128));
      exp.push_back(wr(p, 4'b1000, (p + 1) % 64));
    end
    exp.push_back(wr(63, 4'b1000, 0));
    checks++;
    if (wlog.size() - base != exp.size()) begin errors++; $display("FAIL overflow write_count got=%0d want=%0d", wlog.size() - base, exp.size()); end
    foreach (exp[i]) begin
      got = (base + i < wlog.size()) ? wlog[base + i] : 18'bx;
      checks++;
      if (got !== exp[i]) begin errors++; $display("FAIL overflow write%0d got=%h want=%h", i, got, exp[i]); end
    end
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL overflow frame_rdy got=%0d want=1", rdy_total - r0); end
    checks++;
    if (bc < 1536*BITC + RSTC - 1 || bc > 1536*BITC + RSTC + 1) begin
      errors++; $display("FAIL overflow busy_cycles got=%0d want=%0d", bc, 1536*BITC + RSTC);
    end
    $display("frame overflow writes=%0d busy=%0d", wlog.size() - base, bc);
  endtask

  task automatic test_reset_mid();
    int base, r0, bc;
    r0 = rdy_total;
    pulse_start(); send_byte(8'hE1);
    @(negedge clk_in); byte_rdy_in = 1'b1; byte_data_in = 8'hE2;
    @(negedge clk_in); byte_rdy_in = 1'b0;
    checks++;
    if (layer_en_out !== 1'b1) begin errors++; $display("FAIL reset_mid pre_write got=%b want=1", layer_en_out); end
    rst_n_in = 1'b0;
    #1;
    checks++;
    if ({wr_addr_out, byte_en_out, byte_data_out, layer_en_out, frame_rdy_out, busy_out, frame_drop_out} !== 22'h0) begin
      errors++;
      $display("FAIL reset_mid outputs got=%h want=0",
               {wr_addr_out, byte_en_out, byte_data_out, layer_en_out, frame_rdy_out, busy_out, frame_drop_out});
    end
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    base = wlog.size();
    pulse_start(); send_pixel(8'hF1, 8'hF2, 8'hF3); pulse_end();
    wait_busy_rise("reset_mid"); wait_busy_fall("reset_mid", bc);
    checks++;
    if (wlog.size() - base != 5) begin errors++; $display("FAIL reset_mid write_count got=%0d want=5", wlog.size() - base); end
    checks++;
    if (((wlog.size() > base + 3) ? wlog[base + 3] : 18'bx) !== wr(0, 4'b1000, 1)) begin
      errors++; $display("FAIL reset_mid link got=%h want=%h", (wlog.size() > base + 3) ? wlog[base + 3] : 18'bx, wr(0, 4'b1000, 1));
    end
    checks++;
    if (rdy_total - r0 != 1) begin errors++; $display("FAIL reset_mid frame_rdy got=%0d want=1", rdy_total - r0); end
    $display("frame reset_mid writes=%0d busy=%0d", wlog.size() - base, bc);
  endtask

  initial begin
    test_reset();
    test_one_pixel();
    test_three_pixels();
    test_partial();
    test_empty_frame();
    test_byte_end_same();
    test_drop();
    test_overflow();
    test_reset_mid();
    checks++;
    if (drop_total != 1) begin errors++; $display("FAIL drop_total got=%0d want=1", drop_total); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
